// File: rtl/gf_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gf_pkg
//  Purpose  : Shared types and constants for the iterative GF(2^W) multiplier.
//             FSM state encoding, the AES reduction polynomial and the
//             MixColumns / InvMixColumns coefficients.
//  Revision : 1.0  initial release
// ============================================================================
package gf_pkg;

    // Controller states, with an explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // x^8 + x^4 + x^3 + x + 1, with the x^8 term dropped.
    localparam logic [7:0] c_AES_POLY8 = 8'h1B;

    // MixColumns (02, 03) and InvMixColumns (09, 0B, 0D, 0E) coefficients.
    localparam logic [7:0] c_MC_02 = 8'h02;
    localparam logic [7:0] c_MC_03 = 8'h03;
    localparam logic [7:0] c_MC_09 = 8'h09;
    localparam logic [7:0] c_MC_0B = 8'h0B;
    localparam logic [7:0] c_MC_0D = 8'h0D;
    localparam logic [7:0] c_MC_0E = 8'h0E;

endpackage : gf_pkg
`default_nettype wire

// File: rtl/gf_mul_seq_xtime.sv
`default_nettype none
// ============================================================================
//  Module   : gf_xtime
//  Purpose  : Combinational multiply-by-x in GF(2^W). Shifts left by one bit
//             and folds the bit that leaves the field back in through POLY.
//  Ports    : i_x  [W-1:0]  field element
//             o_y  [W-1:0]  x * i_x mod (x^W + POLY)
//  Revision : 1.0  initial release
// ============================================================================
module gf_xtime #(
    parameter int            W    = 8,
    parameter logic [W-1:0]  POLY = W'(8'h1B)
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    // The MSB shifted out is the x^W term; it is replaced by POLY.
    assign o_y = {i_x[W-2:0], 1'b0} ^ (i_x[W-1] ? POLY : '0);

endmodule : gf_xtime
`default_nettype wire

// File: rtl/gf_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : gf_mul_seq
//  Purpose  : Iterative GF(2^W) multiplier, P = A*B mod (x^W + POLY).
//             The multiplier is consumed LSB-first, one bit per clock, and
//             the multiplicand is advanced by a single shared xtime step.
//             Valid/ready handshakes are used on the operand and result sides.
//  Ports    : clk        clock
//             rst_n      synchronous active-low reset
//             in_valid   operand pair valid
//             in_ready   block can accept operands
//             a, b [W]   multiplicand, multiplier
//             out_valid  product valid
//             out_ready  consumer accepts product
//             p    [W]   product
//  Options  : GF_MUL_EARLY_EXIT_EN - when defined, RUN ends as soon as the
//             remaining multiplier bits are all zero. Latency becomes
//             (index of highest set bit of b) + 2, or 1 for b == 0.
//             Results are the same as in the fixed-latency build.
//  Revision : 1.0  initial release
// ============================================================================
module gf_mul_seq
    import gf_pkg::*;
#(
    parameter int            W    = 8,
    parameter logic [W-1:0]  POLY = W'(c_AES_POLY8)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  p
);

    // The step counter must hold W-1. One extra value of headroom is kept
    // because the early-exit build can complete W steps before it exits.
    localparam int             CW     = $clog2(W + 1);
    localparam logic [CW-1:0]  c_LAST = CW'(W - 1);

    gf_state_e      r_state_q,     w_state_d;
    logic [W-1:0]   r_a_q,         w_a_d;
    logic [W-1:0]   r_b_q,         w_b_d;
    logic [W-1:0]   r_acc_q,       w_acc_d;
    logic [CW-1:0]  r_cnt_q,       w_cnt_d;
    logic [W-1:0]   r_p_q,         w_p_d;
    logic           r_in_ready_q,  w_in_ready_d;
    logic           r_out_valid_q, w_out_valid_d;

    logic [W-1:0]   w_a_xt;
    logic [W-1:0]   w_acc_step;

    gf_xtime #(
        .W    (W),
        .POLY (POLY)
    ) u_xtime (
        .i_x (r_a_q),
        .o_y (w_a_xt)
    );

    // Accumulator value after the current step: add a_reg when b_reg[0].
    assign w_acc_step = r_b_q[0] ? (r_acc_q ^ r_a_q) : r_acc_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;
        w_p_d         = r_p_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;

        case (r_state_q)
            IDLE: begin
                if (in_valid && r_in_ready_q) begin
                    w_a_d        = a;
                    w_b_d        = b;
                    w_acc_d      = '0;
                    w_cnt_d      = '0;
                    w_in_ready_d = 1'b0;
                    w_state_d    = RUN;
                end
            end

            RUN: begin
`ifdef GF_MUL_EARLY_EXIT_EN
                // No multiplier bits left: the accumulator is already final.
                // This test alone ends the run, since b_reg is empty after at
                // most W shifts.
                if (r_b_q == '0) begin
                    w_p_d         = r_acc_q;
                    w_out_valid_d = 1'b1;
                    w_state_d     = DONE;
                end else begin
                    w_acc_d = w_acc_step;
                    w_a_d   = w_a_xt;
                    w_b_d   = r_b_q >> 1;
                    w_cnt_d = r_cnt_q + 1'b1;
                end
`else
                w_acc_d = w_acc_step;
                w_a_d   = w_a_xt;
                w_b_d   = r_b_q >> 1;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST) begin
                    w_p_d         = w_acc_step;
                    w_out_valid_d = 1'b1;
                    w_state_d     = DONE;
                end
`endif
            end

            DONE: begin
                // p stays put until the consumer takes it. The block returns
                // to IDLE first, so a new operand cannot be accepted in the
                // retirement cycle.
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_state_d     = IDLE;
                end
            end

            default: begin
                w_out_valid_d = 1'b0;
                w_in_ready_d  = 1'b1;
                w_state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_p_q         <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_p_q         <= w_p_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign p         = r_p_q;

endmodule : gf_mul_seq
`default_nettype wire
